// File: rtl/micro_seq_pkg.sv
// -----------------------------------------------------------------------------
// micro_seq_pkg
// Shared definitions for the microprogram sequencer:
//   OP_W      : width of the sequencing op field
//   op_e      : op encoding (NEXT, JUMP, JCOND, CALL, RET, HOLD, LDCNT, DJNZ)
//   sp_width  : stack-pointer width able to count 0..depth
// -----------------------------------------------------------------------------
package micro_seq_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NEXT  = 3'b000,
        OP_JUMP  = 3'b001,
        OP_JCOND = 3'b010,
        OP_CALL  = 3'b011,
        OP_RET   = 3'b100,
        OP_HOLD  = 3'b101,
        OP_LDCNT = 3'b110,
        OP_DJNZ  = 3'b111
    } op_e;

    // The pointer must represent "depth" itself (stack full), hence depth+1.
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/micro_stack.sv
// -----------------------------------------------------------------------------
// micro_stack
// Return-address LIFO for the microprogram sequencer.
// Ports:
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   push, pop : push din / pop top; push-when-full and pop-when-empty ignored
//   din       : value to push
//   top       : current top-of-stack entry (valid when !empty)
//   full      : registered, stack holds STACK_DEPTH entries
//   empty     : registered, stack holds no entries
// Reset clears the pointer only; entry contents are simply abandoned.
// -----------------------------------------------------------------------------
module micro_stack
    import micro_seq_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int SP_W  = sp_width(STACK_DEPTH);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] mem [0:(2**IDX_W)-1];
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_next;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_idx  = IDX_W'(sp);
    assign rd_idx  = IDX_W'(sp - SP_W'(1));
    assign top     = mem[rd_idx];

    always_comb begin
        sp_next = sp;
        if (do_push) begin
            sp_next = sp + SP_W'(1);
        end else if (do_pop) begin
            sp_next = sp - SP_W'(1);
        end
    end

    // Flags are registered from the next pointer so they move with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            sp    <= sp_next;
            full  <= (sp_next == SP_W'(STACK_DEPTH));
            empty <= (sp_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// -----------------------------------------------------------------------------
// micro_sequencer
// Generates the control-store micro-address (upc) from the op/target fields of
// the microinstruction register. Supports NEXT, JUMP, conditional jump,
// CALL/RET through a return stack, HOLD and, optionally, a loop counter.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   en           : advance strobe; 0 freezes all state (clr_err still acts)
//   op, cond     : sequencing op and branch condition
//   target       : jump/call target, also loop-count load value
//   clr_err      : clears the sticky ovf/unf flags
//   upc          : registered micro-address
//   stack_full   : return stack holds STACK_DEPTH entries
//   stack_empty  : return stack holds no entries
//   ovf          : sticky, CALL attempted while stack full
//   unf          : sticky, RET attempted while stack empty
// Configuration macro: MSEQ_LOOP_EN adds the loop counter used by LDCNT/DJNZ;
// without it those ops behave as NEXT.
// -----------------------------------------------------------------------------
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [OP_W-1:0]   op,
    input  logic              cond,
    input  logic [ADDR_W-1:0] target,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] upc,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              ovf,
    output logic              unf
);

    if (STACK_DEPTH < 1 || CNT_W < 1) begin : g_bad_param
        $error("micro_sequencer: STACK_DEPTH and CNT_W must be >= 1");
    end

    logic [ADDR_W-1:0] upc_inc;
    logic [ADDR_W-1:0] upc_next;
    logic [ADDR_W-1:0] stack_top;
    logic              push;
    logic              pop;
    logic              ovf_set;
    logic              unf_set;

`ifdef MSEQ_LOOP_EN
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
`endif

    // Wraps modulo 2^ADDR_W; the pushed return address uses the same value.
    assign upc_inc = upc + ADDR_W'(1);

    micro_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (upc_inc),
        .top   (stack_top),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_comb begin
        upc_next = upc;
        push     = 1'b0;
        pop      = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
`ifdef MSEQ_LOOP_EN
        cnt_next = cnt;
`endif
        if (en) begin
            case (op_e'(op))
                OP_NEXT:  upc_next = upc_inc;
                OP_JUMP:  upc_next = target;
                OP_JCOND: upc_next = cond ? target : upc_inc;
                OP_CALL: begin
                    // A call that cannot push is skipped, not taken.
                    if (stack_full) begin
                        upc_next = upc_inc;
                        ovf_set  = 1'b1;
                    end else begin
                        push     = 1'b1;
                        upc_next = target;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        upc_next = upc_inc;
                        unf_set  = 1'b1;
                    end else begin
                        pop      = 1'b1;
                        upc_next = stack_top;
                    end
                end
                OP_HOLD:  upc_next = upc;
                OP_LDCNT: begin
                    upc_next = upc_inc;
`ifdef MSEQ_LOOP_EN
                    cnt_next = CNT_W'(target);
`endif
                end
                OP_DJNZ: begin
`ifdef MSEQ_LOOP_EN
                    if (cnt != '0) begin
                        cnt_next = cnt - CNT_W'(1);
                        upc_next = target;
                    end else begin
                        upc_next = upc_inc;
                    end
`else
                    upc_next = upc_inc;
`endif
                end
            endcase
        end
    end

    // A new error takes precedence over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            upc <= upc_next;
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clr_err) begin
                ovf <= 1'b0;
            end
            if (unf_set) begin
                unf <= 1'b1;
            end else if (clr_err) begin
                unf <= 1'b0;
            end
        end
    end

`ifdef MSEQ_LOOP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end
`endif

endmodule
